gon_ybus_collector: RTL and testbench
=====================================

Name: gon_ybus_collector

Overview:
- Downstream stage of the global output network X-buses. It sequences psum read-out from one selected PE row's X-bus at a time.
- On each start it latches a row tag and a column tag. It broadcasts the column tag to the X-bus multicast controllers and drives the enable of the selected row only.
- Each granted word is captured into a small FIFO and forwarded to the global buffer over a valid/ready port.

Parameters:
- DATA_WIDTH, 64, psum word width.
- ROW_TAG_WIDTH, 4, row tag width.
- COL_TAG_WIDTH, 4, column tag width.
- NUM_OF_ROWS, 12, number of X-buses (PE rows) served.
- FIFO_DEPTH, 4, output buffer entries; power of two, >= 2.
- COUNT_WIDTH, 8, width of the transfer word count.

Ports:
- link_clk, in, 1, single clock.
- reset, in, 1, synchronous, active-low reset.
- start, in, 1, begin a transfer; sampled only in IDLE.
- start_row_tag, in, ROW_TAG_WIDTH, row to read.
- start_col_tag, in, COL_TAG_WIDTH, column tag for the X-bus controllers.
- start_count, in, COUNT_WIDTH, words to transfer.
- xbus_data, in, DATA_WIDTH x NUM_OF_ROWS, per-row X-bus data bus.
- xbus_ready, in, NUM_OF_ROWS, per-row "word available" (OR of that row's controller ready outputs).
- xbus_enable, out, NUM_OF_ROWS, per-row enable into the X-bus.
- col_tag, out, COL_TAG_WIDTH, broadcast column tag.
- glb_data, out, DATA_WIDTH, FIFO head.
- glb_valid, out, 1, FIFO non-empty.
- glb_ready, in, 1, global buffer accepts the head.
- busy, out, 1, high in RUN and DONE.
- done, out, 1, one-cycle pulse at transfer end.
- tag_error, out, 1, one-cycle pulse on an out-of-range row tag.

Behaviour:
- Reset (reset==0 at a link_clk edge):
  - FSM goes to IDLE; FIFO empties.
  - All outputs go to 0: xbus_enable, col_tag, glb_valid, glb_data, busy, done, tag_error.
  - Reset mid-transfer abandons the transfer; no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start with start_row_tag >= NUM_OF_ROWS: pulse tag_error next cycle, stay IDLE.
  - start with start_count == 0: go to DONE directly; no enables issued.
  - Otherwise: latch row_tag, col_tag and remaining = start_count, then go to RUN.
- RUN, grant rule (combinational):
  - grant = xbus_ready[row_tag] AND (fifo_count < FIFO_DEPTH OR pop_this_cycle).
  - xbus_enable[row_tag] = grant; all other enable bits are 0.
- RUN, on a grant:
  - xbus_data[row_tag] is pushed into the FIFO at the same edge (zero-cycle capture).
  - remaining decrements.
  - When remaining reaches 0 on that edge, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. The FIFO keeps draining independently.
- col_tag output holds the latched tag from RUN entry until the next start. It resets to 0.
- FIFO behaviour:
  - glb_valid = !empty; glb_data = head.
  - Pop when glb_valid AND glb_ready.
  - Push and pop in the same cycle is legal when full (occupancy unchanged) and when empty (pass-through still takes one cycle; no combinational xbus->glb path).
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- start while busy is ignored.
- The latency xbus grant -> glb_valid is 1 cycle.
- The FIFO never overflows: grant is suppressed when full and no pop occurs that cycle.
- Throughput is one word per cycle when xbus_ready and glb_ready are held high.

Decomposition:
- Package gon_pkg:
  - state enum (IDLE, RUN, DONE);
  - default width constants (DATA_WIDTH, ROW/COL tag widths).
- One sub-module: gon_sync_fifo (parameterised DATA_WIDTH, FIFO_DEPTH; push, pop, full, empty, count). It is instantiated once.
- The FSM, grant and tag latching stay in gon_ybus_collector.

Test Plan:
- Basic transfer:
  - Stimulus: start, row 3, col 5, count 4; xbus_ready[3]=1, glb_ready=1; data 0xA0..0xA3.
  - Required: xbus_enable[3] high for 4 consecutive cycles, col_tag=5, glb_data A0..A3 on consecutive cycles each one cycle after capture, done one cycle after the last grant.
- Backpressure:
  - Stimulus: count 8, glb_ready=0.
  - Required: exactly 4 grants, then enable drops and glb_valid stays 1. Raise glb_ready → the remaining 4 are granted with no loss or duplication; output order A0..A7.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, glb_ready=1, xbus_ready=1.
  - Required: grant continues every cycle and occupancy stays 4.
- Tag error and zero count:
  - Stimulus: start, row 12.
  - Required: tag_error pulse, no enable, busy=0. Start with count 0 → done pulse one cycle later, no enable.
- Busy and stalled source:
  - Stimulus: start with count 3, then a second start during RUN; xbus_ready[3] toggles 1,0,1,0,1.
  - Required: second start ignored, exactly 3 grants, each only in a cycle with ready=1.
- Reset mid-transfer:
  - Stimulus: assert reset after 2 of 6 words.
  - Required: next cycle all outputs are 0, FIFO empty, no done. A fresh start then works normally.

Source files
------------

// File: rtl/gon_pkg.sv
// Shared types and default widths for the global output network Y-bus collector.
package gon_pkg;

  localparam int DATA_WIDTH_DEF    = 64;
  localparam int ROW_TAG_WIDTH_DEF = 4;
  localparam int COL_TAG_WIDTH_DEF = 4;
  localparam int NUM_OF_ROWS_DEF   = 12;
  localparam int FIFO_DEPTH_DEF    = 4;
  localparam int COUNT_WIDTH_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gon_ybus_collector_if.sv
// Valid/ready word port from the collector to the global buffer.
interface gon_ybus_collector_if
  import gon_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [DATA_WIDTH-1:0] glb_data;
  logic                  glb_valid;
  logic                  glb_ready;

  modport master (output glb_data, output glb_valid, input glb_ready);
  modport slave  (input glb_data, input glb_valid, output glb_ready);

endinterface

// File: rtl/gon_sync_fifo.sv
// Small synchronous FIFO; the head reads as zero while empty so no stale word leaks out.
module gon_sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          link_clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: every variable gets its default first so no path through this block can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge link_clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy tracking and the empty-gated head cover it.
  always_ff @(posedge link_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/gon_ybus_collector.sv
// Sequences psum read-out from one selected PE row's X-bus into a FIFO toward the global buffer.
module gon_ybus_collector
  import gon_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ROW_TAG_WIDTH = ROW_TAG_WIDTH_DEF,
  parameter int COL_TAG_WIDTH = COL_TAG_WIDTH_DEF,
  parameter int NUM_OF_ROWS   = NUM_OF_ROWS_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int COUNT_WIDTH   = COUNT_WIDTH_DEF
) (
  input  logic                                  link_clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [ROW_TAG_WIDTH-1:0]              start_row_tag,
  input  logic [COL_TAG_WIDTH-1:0]              start_col_tag,
  input  logic [COUNT_WIDTH-1:0]                start_count,
  input  logic [NUM_OF_ROWS-1:0][DATA_WIDTH-1:0] xbus_data,
  input  logic [NUM_OF_ROWS-1:0]                xbus_ready,
  output logic [NUM_OF_ROWS-1:0]                xbus_enable,
  output logic [COL_TAG_WIDTH-1:0]              col_tag,
  gon_ybus_collector_if.master                  glb,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  tag_error
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]       DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [ROW_TAG_WIDTH:0] NUM_ROWS_C = (ROW_TAG_WIDTH + 1)'(NUM_OF_ROWS);

  state_e                   state_q, state_d;
  logic [ROW_TAG_WIDTH-1:0] row_tag_q, row_tag_d;
  logic [COL_TAG_WIDTH-1:0] col_tag_q, col_tag_d;
  logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;
  logic                     tag_error_q, tag_error_d;

  logic                     grant, pop;
  logic                     fifo_full, fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0]    fifo_head;

  assign pop = !fifo_empty && glb.glb_ready;

  always_comb begin
    state_d     = state_q;
    row_tag_d   = row_tag_q;
    col_tag_d   = col_tag_q;
    remaining_d = remaining_q;
    tag_error_d = 1'b0;
    grant       = 1'b0;
    xbus_enable = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ({1'b0, start_row_tag} >= NUM_ROWS_C) begin
            tag_error_d = 1'b1;
          end else if (start_count == '0) begin
            state_d = DONE;
          end else begin
            row_tag_d   = start_row_tag;
            col_tag_d   = start_col_tag;
            remaining_d = start_count;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        // A pop this cycle frees a slot, so a full FIFO can still accept the word.
        grant = xbus_ready[row_tag_q] && ((fifo_count < DEPTH_C) || pop);
        if (grant) begin
          xbus_enable[row_tag_q] = 1'b1;
          remaining_d            = remaining_q - COUNT_WIDTH'(1);
          if (remaining_q == COUNT_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge link_clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_tag_q   <= '0;
      col_tag_q   <= '0;
      remaining_q <= '0;
      tag_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_tag_q   <= row_tag_d;
      col_tag_q   <= col_tag_d;
      remaining_q <= remaining_d;
      tag_error_q <= tag_error_d;
    end
  end

  gon_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .link_clk  (link_clk),
    .reset     (reset),
    .push      (grant),
    .push_data (xbus_data[row_tag_q]),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  no_overflow_a: assert property (@(posedge link_clk) disable iff (!reset)
                                  !(fifo_full && grant && !pop));

  assign glb.glb_data  = fifo_head;
  assign glb.glb_valid = !fifo_empty;
  assign col_tag       = col_tag_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign tag_error     = tag_error_q;

endmodule

// File: tb/tb_gon_ybus_collector.sv
// Directed bench for gon_ybus_collector: transfer-level model checked every cycle plus literal pins.
module tb_gon_ybus_collector;

  localparam int NR      = 12;
  localparam int DW      = 64;
  localparam int DEPTH   = 4;
  localparam int SRC_ROW = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [3:0]             start_row_tag;
  logic [3:0]             start_col_tag;
  logic [7:0]             start_count;
  logic [NR-1:0][DW-1:0]  xbus_data;
  logic [NR-1:0]          xbus_ready;
  logic [NR-1:0]          xbus_enable;
  logic [3:0]             col_tag;
  logic                   busy, done, tag_error;

  gon_ybus_collector_if #(.DATA_WIDTH(DW)) glb_if ();

  gon_ybus_collector dut (
    .link_clk      (clk),
    .reset         (reset),
    .start         (start),
    .start_row_tag (start_row_tag),
    .start_col_tag (start_col_tag),
    .start_count   (start_count),
    .xbus_data     (xbus_data),
    .xbus_ready    (xbus_ready),
    .xbus_enable   (xbus_enable),
    .col_tag       (col_tag),
    .glb           (glb_if),
    .busy          (busy),
    .done          (done),
    .tag_error     (tag_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: a queue of words owed to the global buffer plus a few flags.
  logic [DW-1:0] q[$];
  bit            m_run, m_fin, m_terr;
  int            m_row, m_rem;
  logic [3:0]    m_col;

  function automatic bit model_pop();
    return (q.size() > 0) && glb_if.glb_ready;
  endfunction

  function automatic bit model_grant();
    return m_run && xbus_ready[m_row] && ((q.size() < DEPTH) || model_pop());
  endfunction

  always @(posedge clk) begin
    bit p, g;
    if (!reset) begin
      q.delete();
      m_run = 0; m_fin = 0; m_terr = 0; m_row = 0; m_rem = 0; m_col = '0;
    end else begin
      p = model_pop();
      g = model_grant();
      if (p) void'(q.pop_front());
      if (g) q.push_back(xbus_data[m_row]);
      m_terr = 0;
      if (m_fin) begin
        m_fin = 0;
      end else if (m_run) begin
        if (g) begin
          m_rem--;
          if (m_rem == 0) begin m_run = 0; m_fin = 1; end
        end
      end else if (start) begin
        if (int'(start_row_tag) >= NR) m_terr = 1;
        else if (start_count == 0) m_fin = 1;
        else begin
          m_run = 1; m_row = int'(start_row_tag);
          m_col = start_col_tag; m_rem = int'(start_count);
        end
      end
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    logic [NR-1:0] exp_en;
    if (cmp_en) begin
      exp_en = '0;
      if (model_grant()) exp_en[m_row] = 1'b1;
      check("xbus_enable", 64'(xbus_enable), 64'(exp_en));
      check("col_tag",     64'(col_tag), 64'(m_col));
      check("glb_valid",   64'(glb_if.glb_valid), 64'(q.size() > 0));
      check("glb_data",    glb_if.glb_data, (q.size() > 0) ? q[0] : 64'h0);
      check("busy",        64'(busy), 64'(m_run || m_fin));
      check("done",        64'(done), 64'(m_fin));
      check("tag_error",   64'(tag_error), 64'(m_terr));
      check("occupancy",   64'(dut.fifo_count), 64'(q.size()));
    end
  end

  // Observation logs of DUT activity, used by the literal checks.
  int            cyc = 0;
  int            g_cyc[$];
  int            d_cyc[$];
  int            o_cyc[$];
  logic [DW-1:0] out_log[$];
  int            te_cnt = 0;
  logic [NR-1:0] en_s = '0;

  always @(negedge clk) begin
    cyc++;
    en_s = xbus_enable;
    if (xbus_enable != '0) g_cyc.push_back(cyc);
    if (done) d_cyc.push_back(cyc);
    if (tag_error) te_cnt++;
    if (glb_if.glb_valid && glb_if.glb_ready) begin
      out_log.push_back(glb_if.glb_data);
      o_cyc.push_back(cyc);
    end
  end

  logic [DW-1:0] src_base;
  int            src_idx;

  // One cycle: the source advances its word whenever its enable was high in the cycle just ended.
  task automatic tick();
    @(posedge clk);
    #1;
    if (en_s[SRC_ROW]) src_idx++;
    xbus_data[SRC_ROW] = src_base + 64'(src_idx);
  endtask

  task automatic new_source(input logic [DW-1:0] base);
    src_base = base;
    src_idx  = 0;
    xbus_data[SRC_ROW] = base;
  endtask

  task automatic issue(input int row, input int col, input int cnt);
    start = 1'b1;
    start_row_tag = 4'(row);
    start_col_tag = 4'(col);
    start_count = 8'(cnt);
    tick();
    start = 1'b0;
  endtask

  int g0, d0, o0, t0;

  initial begin
    reset = 1'b0; start = 1'b0;
    start_row_tag = '0; start_col_tag = '0; start_count = '0;
    xbus_data = '0; xbus_ready = '0; glb_if.glb_ready = 1'b0;
    src_base = '0; src_idx = 0;

    tick();
    cmp_en = 1;
    tick();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_valid", 64'(glb_if.glb_valid), 64'h0);
    check("rst_col_tag", 64'(col_tag), 64'h0);
    reset = 1'b1;
    tick();

    // Basic transfer: row 3, col 5, four words; other rows ready too but never enabled.
    new_source(64'hA0);
    xbus_ready = '1; glb_if.glb_ready = 1'b1;
    g0 = g_cyc.size(); d0 = d_cyc.size(); o0 = out_log.size();
    issue(3, 5, 4);
    repeat (8) tick();
    check("basic_grants", 64'(g_cyc.size() - g0), 64'd4);
    check("basic_consecutive", 64'(g_cyc[g0+3] - g_cyc[g0]), 64'd3);
    check("basic_col_tag", 64'(col_tag), 64'd5);
    for (int i = 0; i < 4; i++) check("basic_word", out_log[o0+i], 64'hA0 + 64'(i));
    check("basic_latency", 64'(o_cyc[o0] - g_cyc[g0]), 64'd1);
    check("basic_done_cnt", 64'(d_cyc.size() - d0), 64'd1);
    check("basic_done_time", 64'(d_cyc[d0] - g_cyc[g0+3]), 64'd1);

    // Backpressure, then full FIFO with simultaneous push and pop.
    new_source(64'hA0);
    xbus_ready = 12'h008; glb_if.glb_ready = 1'b0;
    g0 = g_cyc.size(); o0 = out_log.size();
    issue(3, 7, 8);
    repeat (8) tick();
    @(negedge clk);
    check("bp_grants", 64'(g_cyc.size() - g0), 64'd4);
    check("bp_valid", 64'(glb_if.glb_valid), 64'h1);
    check("bp_full_occ", 64'(dut.fifo_count), 64'd4);
    tick();
    glb_if.glb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("pp_occ", 64'(dut.fifo_count), 64'd4);
      check("pp_grant", 64'(xbus_enable), 64'h008);
      tick();
    end
    repeat (6) tick();
    check("bp_total_grants", 64'(g_cyc.size() - g0), 64'd8);
    check("bp_total_words", 64'(out_log.size() - o0), 64'd8);
    for (int i = 0; i < 8; i++) check("bp_word", out_log[o0+i], 64'hA0 + 64'(i));

    // Out-of-range row tag, then zero-length transfer.
    xbus_ready = '1;
    t0 = te_cnt; g0 = g_cyc.size(); d0 = d_cyc.size();
    issue(12, 1, 3);
    @(negedge clk);
    check("terr_pulse", 64'(tag_error), 64'h1);
    check("terr_busy", 64'(busy), 64'h0);
    tick();
    @(negedge clk);
    check("terr_one_cycle", 64'(te_cnt - t0), 64'd1);
    issue(2, 1, 0);
    @(negedge clk);
    check("zero_done", 64'(done), 64'h1);
    tick();
    tick();
    check("zero_no_enable", 64'(g_cyc.size() - g0), 64'd0);
    check("zero_done_cnt", 64'(d_cyc.size() - d0), 64'd1);

    // Second start while busy, source stalling every other cycle.
    begin
      bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      new_source(64'hB0);
      xbus_ready = '0;
      g0 = g_cyc.size(); d0 = d_cyc.size(); o0 = out_log.size();
      issue(3, 9, 3);
      for (int i = 0; i < 5; i++) begin
        xbus_ready[SRC_ROW] = pat[i];
        start = (i == 1);
        start_row_tag = 4'd5; start_col_tag = 4'd2; start_count = 8'd7;
        tick();
      end
      start = 1'b0;
      repeat (5) tick();
    end
    check("stall_grants", 64'(g_cyc.size() - g0), 64'd3);
    check("stall_gap0", 64'(g_cyc[g0+1] - g_cyc[g0]), 64'd2);
    check("stall_gap1", 64'(g_cyc[g0+2] - g_cyc[g0+1]), 64'd2);
    check("stall_col_tag", 64'(col_tag), 64'd9);
    check("stall_done_cnt", 64'(d_cyc.size() - d0), 64'd1);
    for (int i = 0; i < 3; i++) check("stall_word", out_log[o0+i], 64'hB0 + 64'(i));

    // Reset in the middle of a six-word transfer.
    new_source(64'hD0);
    xbus_ready = 12'h008; glb_if.glb_ready = 1'b0;
    d0 = d_cyc.size();
    issue(3, 4, 6);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_enable", 64'(xbus_enable), 64'h0);
    check("mid_rst_valid", 64'(glb_if.glb_valid), 64'h0);
    check("mid_rst_data", glb_if.glb_data, 64'h0);
    check("mid_rst_busy", 64'(busy), 64'h0);
    check("mid_rst_col", 64'(col_tag), 64'h0);
    check("mid_rst_occ", 64'(dut.fifo_count), 64'h0);
    repeat (3) tick();
    check("mid_rst_no_done", 64'(d_cyc.size() - d0), 64'd0);
    new_source(64'hC0);
    glb_if.glb_ready = 1'b1;
    o0 = out_log.size();
    issue(3, 6, 2);
    repeat (5) tick();
    check("fresh_words", 64'(out_log.size() - o0), 64'd2);
    check("fresh_word0", out_log[o0], 64'hC0);
    check("fresh_word1", out_log[o0+1], 64'hC1);
    check("fresh_done_cnt", 64'(d_cyc.size() - d0), 64'd1);
    check("fresh_col_tag", 64'(col_tag), 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
